// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master round-robin peripheral bus arbiter with burst limit (ARB_FIXED_PRIO_EN selects fixed master-0 priority)
module periph_bus_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_rd,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_gnt,
  input  logic        m1_req,
  input  logic        m1_rd,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_gnt,
  output logic        p_rd,
  output logic        p_wr,
  output logic [31:0] p_addr,
  output logic [31:0] p_wdata,
  input  logic [31:0] p_rdata,
  output logic        busy
);
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif
  localparam logic [3:0] BURST = 4'(MAX_BURST);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic       last_q, last_d;
  assign m0_gnt  = state_q == GNT0;
  assign m1_gnt  = state_q == GNT1;
  assign busy    = state_q != IDLE;
  assign m0_ack  = m0_gnt & m0_req;
  assign m1_ack  = m1_gnt & m1_req;
  assign cnt_inc = cnt_q + 4'd1;
  // Route the acked master onto the peripheral bus; write wins over a simultaneous read
  always_comb begin
    p_wr     = m0_ack ? m0_wr : m1_ack ? m1_wr : 1'b0;
    p_rd     = m0_ack ? (m0_rd & ~m0_wr) : m1_ack ? (m1_rd & ~m1_wr) : 1'b0;
    p_addr   = m0_ack ? m0_addr : m1_ack ? m1_addr : 32'h0;
    p_wdata  = m0_ack ? m0_wdata : m1_ack ? m1_wdata : 32'h0;
    m0_rdata = (m0_ack & p_rd) ? p_rdata : 32'h0;
    m1_rdata = (m1_ack & p_rd) ? p_rdata : 32'h0;
  end
  // Next-state: arbitration, burst limit, hand-over and last-served tracking
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_req && (!m1_req || last_q || FIXED_PRIO)) state_d = GNT0;
        else if (m1_req) state_d = GNT1;
      end
      GNT0: begin
        if (!m0_req) state_d = m1_req ? GNT1 : IDLE;
        else if (!FIXED_PRIO && m1_req && cnt_inc == BURST) state_d = GNT1;
        else cnt_d = (cnt_inc == BURST) ? 4'd0 : cnt_inc;
      end
      GNT1: begin
        if (!m1_req) state_d = m0_req ? GNT0 : IDLE;
        else if (m0_req && (FIXED_PRIO || cnt_inc == BURST)) state_d = GNT0;
        else cnt_d = (cnt_inc == BURST) ? 4'd0 : cnt_inc;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = 4'd0;
    if (state_d != state_q && state_q != IDLE) last_d = state_q == GNT1;
  end
  // State registers; reset leaves master 1 as last served so master 0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: doc/periph_bus_arbiter.md
PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive acked accesses per grant while the other master waits (legal 1..15).
REQ-002 The block SHALL have port clk, input, 1, single system clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ports m0_req, m1_req, input, 1 each, access request from master 0 (CPU) / master 1 (aux).
REQ-005 The block SHALL have ports m0_rd, m0_wr, m1_rd, m1_wr, input, 1 each, access type per master.
REQ-006 The block SHALL have ports m0_addr, m0_wdata, m1_addr, m1_wdata, input, 32 each, address and write data per master.
REQ-007 The block SHALL have ports m0_ack, m1_ack, output, 1 each, access completes this cycle.
REQ-008 The block SHALL have ports m0_rdata, m1_rdata, output, 32 each, read data valid with ack.
REQ-009 The block SHALL have ports m0_gnt, m1_gnt, output, 1 each, registered grant status.
REQ-010 The block SHALL have ports p_rd, p_wr, output, 1 each; p_addr, p_wdata, output, 32 each, peripheral-side bus.
REQ-011 The block SHALL have port p_rdata, input, 32, peripheral combinational read data.
REQ-012 The block SHALL have port busy, output, 1, high when state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, GNT0, GNT1; m0_gnt = (state==GNT0), m1_gnt = (state==GNT1), both registered.
REQ-014 In IDLE, if any mN_req is high, the next state SHALL be GNT of the winning master; no peripheral access occurs in IDLE (first-access latency is exactly 1 cycle after req is seen).
REQ-015 Arbitration with both requests in IDLE SHALL pick the master not served last (round-robin via 1-bit last pointer).
REQ-016 In GNTx with mx_req high, the peripheral bus SHALL carry master x's addr/wdata/rd/wr combinationally, and mx_ack SHALL be high that cycle.
REQ-017 If a master asserts rd and wr together, p_wr SHALL be forwarded and p_rd forced low; ack still issued, rdata = 0.
REQ-018 mx_rdata SHALL equal p_rdata when mx_ack and p_rd are high, else 32'h0.
REQ-019 When no master is acked, p_rd, p_wr SHALL be 0 and p_addr, p_wdata SHALL be 32'h0.
REQ-020 A 4-bit burst counter SHALL increment per acked cycle and clear on every state change.
REQ-021 In GNTx, if mx_req is low: next = GNT of the other master if its req is high, else IDLE; no ack issued that cycle.
REQ-022 In GNTx, if the acked access brings the counter to MAX_BURST and the other req is high, next SHALL be GNT of the other master; if the other req is low, the grant holds and the counter clears.
REQ-023 On leaving GNTx, last pointer SHALL be set to x.
REQ-024 Masters SHALL hold req, rd/wr, addr, wdata stable until ack; req dropped before ack SHALL cancel the access with no peripheral strobe.
REQ-025 A non-granted master's ack and rdata SHALL be 0 regardless of its inputs.

Reset
REQ-026 Reset assertion SHALL force state=IDLE, counter=0, last pointer=1 (master 0 wins first tie) immediately, independent of clk.
REQ-027 During and after reset, until next grant: m0_gnt=m1_gnt=0, acks=0, busy=0, p_rd=p_wr=0; a burst interrupted by reset SHALL NOT resume.

Configuration
REQ-028 With macro ARB_FIXED_PRIO_EN defined, master 0 SHALL always win ties in IDLE and SHALL pre-empt GNT1 after the current acked cycle whenever m0_req is high (MAX_BURST ignored for master 1; master 0 never pre-empted).
REQ-029 Without ARB_FIXED_PRIO_EN, round-robin and MAX_BURST rules of REQ-015/REQ-022 SHALL apply.

Verification
REQ-030 Reset release, m0_req=1 wr addr 0x4000000C wdata 0x5A -> cycle 1 m0_gnt=1, m0_ack=1, p_wr=1, p_addr=0x4000000C, p_wdata=0x5A.
REQ-031 Both reqs rise together after reset -> GNT0 first; m0 drops after 1 ack -> GNT1 next cycle with no idle gap.
REQ-032 Both reqs held continuously, MAX_BURST=4 -> grants alternate 4 acks m0, 4 acks m1, repeated; no cycle with both acks.
REQ-033 m1 read of 0x40000010 with p_rdata=0x000000A5 -> m1_rdata=0xA5 with m1_ack; m0_rdata=0.
REQ-034 Reset asserted mid-burst in GNT1 -> same-instant busy=0, m1_gnt=0, p_rd=p_wr=0; after release with both reqs, m0 granted first.
REQ-035 ARB_FIXED_PRIO_EN defined, m1 in burst, m0_req rises -> after m1's current ack, GNT0 next cycle.
